// File: rtl/pc_irq_unit.sv
// Next-PC and interrupt/exception sequencer: owns the PC, EPC, pending and mask registers.
// Arbitrates exception > IRQ > normal flow on every non-stalled cycle.
module pc_irq_unit #(
   parameter int unsigned XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h0000_0000),
   parameter logic [XLEN-1:0] IRQ_VEC   = XLEN'(32'h8000_0004),
   parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(32'h8000_0008),
   parameter int unsigned NUM_IRQ  = 4,
   parameter bit          IRQ_EDGE = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic [2:0]         pc_sel,
   input  logic               branch_taken,
   input  logic [15:0]        imm16,
   input  logic [25:0]        instr_index,
   input  logic [XLEN-1:0]    jr_target,
   input  logic               exc_req,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               mask_we,
   input  logic [NUM_IRQ-1:0] mask_wdata,
   output logic [XLEN-1:0]    pc,
   output logic [XLEN-1:0]    pc_plus4,
   output logic [XLEN-1:0]    epc,
   output logic               kernel,
   output logic               irq_taken,
   output logic [3:0]         irq_id,
   output logic               exc_taken,
   output logic [NUM_IRQ-1:0] irq_pending,
   output logic [NUM_IRQ-1:0] irq_mask
);

   logic [XLEN-1:0]    pc_q, pc_d;
   logic [XLEN-1:0]    epc_q, epc_d;
   logic [NUM_IRQ-1:0] pend_q, pend_d;
   logic [NUM_IRQ-1:0] mask_q, mask_d;
   logic [NUM_IRQ-1:0] prev_q;
   logic               irq_taken_q, irq_taken_d;
   logic               exc_taken_q, exc_taken_d;
   logic [3:0]         irq_id_q, irq_id_d;

   logic [XLEN-1:0]    pc_inc;
   logic [XLEN-1:0]    br_off;
   logic [XLEN-1:0]    br_tgt, jmp_tgt, jr_tgt, norm_tgt;
   logic [NUM_IRQ-1:0] elig;
   logic [NUM_IRQ-1:0] clr;
   logic [3:0]         sel_id;
   logic               exc_ev, irq_ev;

   assign pc_inc = pc_q + XLEN'(4);
   assign br_off = {{(XLEN-18){imm16[15]}}, imm16, 2'b00};
   assign elig   = pend_q & mask_q;

   // Lowest eligible index wins: scan downward so the last hit is the smallest.
   always_comb begin
      sel_id = 4'd0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (elig[i]) sel_id = 4'(i);
      end
   end

   always_comb begin
      br_tgt     = branch_taken ? (pc_inc + br_off) : pc_inc;
      br_tgt[31] = pc_q[31];
      jmp_tgt        = pc_inc;
      jmp_tgt[31:0]  = {pc_q[31], pc_inc[30:28], instr_index, 2'b00};
      // User mode can never jump into kernel space; kernel may drop back to user.
      jr_tgt     = jr_target;
      jr_tgt[31] = jr_target[31] & pc_q[31];
      case (pc_sel[1:0])
         2'd1:    norm_tgt = br_tgt;
         2'd2:    norm_tgt = jmp_tgt;
         2'd3:    norm_tgt = jr_tgt;
         default: norm_tgt = pc_inc;
      endcase
   end

   always_comb begin
      exc_ev = ~stall & (exc_req | pc_sel[2]);
      irq_ev = ~stall & ~exc_ev & (|elig) & ~pc_q[31];

      pc_d        = pc_q;
      epc_d       = epc_q;
      irq_id_d    = irq_id_q;
      irq_taken_d = irq_ev;
      exc_taken_d = exc_ev;
      clr         = '0;

      if (exc_ev) begin
         pc_d  = EXC_VEC;
         epc_d = pc_q;
      end else if (irq_ev) begin
         pc_d        = IRQ_VEC;
         epc_d       = pc_q;
         irq_id_d    = sel_id;
         clr[sel_id] = 1'b1;
      end else if (!stall) begin
         pc_d = norm_tgt;
      end

      // A new edge on the line being cleared keeps it pending.
      if (IRQ_EDGE) pend_d = (pend_q & ~clr) | (irq_in & ~prev_q);
      else          pend_d = irq_in;

      mask_d = mask_we ? mask_wdata : mask_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q        <= RESET_VEC;
         epc_q       <= '0;
         pend_q      <= '0;
         mask_q      <= '0;
         prev_q      <= '0;
         irq_taken_q <= 1'b0;
         exc_taken_q <= 1'b0;
         irq_id_q    <= 4'd0;
      end else begin
         pc_q        <= pc_d;
         epc_q       <= epc_d;
         pend_q      <= pend_d;
         mask_q      <= mask_d;
         prev_q      <= irq_in;
         irq_taken_q <= irq_taken_d;
         exc_taken_q <= exc_taken_d;
         irq_id_q    <= irq_id_d;
      end
   end

   assign pc          = pc_q;
   assign pc_plus4    = pc_inc;
   assign epc         = epc_q;
   assign kernel      = pc_q[31];
   assign irq_taken   = irq_taken_q;
   assign irq_id      = irq_id_q;
   assign exc_taken   = exc_taken_q;
   assign irq_pending = pend_q;
   assign irq_mask    = mask_q;

endmodule

// File: tb/tb_pc_irq_unit.sv
// Directed bench for pc_irq_unit: expectations queued before each clock, drained after it.
module tb_pc_irq_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic [2:0]  pc_sel;
   logic        branch_taken;
   logic [15:0] imm16;
   logic [25:0] instr_index;
   logic [31:0] jr_target;
   logic        exc_req;
   logic [3:0]  irq_in;
   logic        mask_we;
   logic [3:0]  mask_wdata;
   logic [31:0] pc, pc_plus4, epc;
   logic        kernel, irq_taken, exc_taken;
   logic [3:0]  irq_id, irq_pending, irq_mask;

   pc_irq_unit dut (
      .clk(clk), .reset(reset), .stall(stall), .pc_sel(pc_sel),
      .branch_taken(branch_taken), .imm16(imm16), .instr_index(instr_index),
      .jr_target(jr_target), .exc_req(exc_req), .irq_in(irq_in),
      .mask_we(mask_we), .mask_wdata(mask_wdata), .pc(pc), .pc_plus4(pc_plus4),
      .epc(epc), .kernel(kernel), .irq_taken(irq_taken), .irq_id(irq_id),
      .exc_taken(exc_taken), .irq_pending(irq_pending), .irq_mask(irq_mask)
   );

   always #5 clk = ~clk;

   localparam int K_PC = 0, K_EPC = 1, K_IRQT = 2, K_EXCT = 3, K_ID = 4,
                  K_PEND = 5, K_MASK = 6, K_PC4 = 7, K_KERN = 8;

   typedef struct {
      int          kind;
      int          step;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;
   int   step_no = 0;

   function automatic logic [31:0] observe(int kind);
      case (kind)
         K_PC:    return pc;
         K_EPC:   return epc;
         K_IRQT:  return 32'(irq_taken);
         K_EXCT:  return 32'(exc_taken);
         K_ID:    return 32'(irq_id);
         K_PEND:  return 32'(irq_pending);
         K_MASK:  return 32'(irq_mask);
         K_PC4:   return pc_plus4;
         default: return 32'(kernel);
      endcase
   endfunction

   function automatic string kname(int kind);
      case (kind)
         K_PC:    return "pc";
         K_EPC:   return "epc";
         K_IRQT:  return "irq_taken";
         K_EXCT:  return "exc_taken";
         K_ID:    return "irq_id";
         K_PEND:  return "irq_pending";
         K_MASK:  return "irq_mask";
         K_PC4:   return "pc_plus4";
         default: return "kernel";
      endcase
   endfunction

   task automatic expect_val(input int kind, input logic [31:0] val);
      exp_t e;
      e.kind = kind;
      e.step = step_no;
      e.val  = val;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t        e;
      logic [31:0] o;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = observe(e.kind);
         n_total++;
         assert (o === e.val) n_pass++;
         else $error("FAIL step%0d %s observed=%h expected=%h", e.step, kname(e.kind), o, e.val);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      drain();
      step_no++;
   endtask

   task automatic idle_inputs();
      stall = 0; pc_sel = 3'd0; branch_taken = 0; imm16 = '0; instr_index = '0;
      jr_target = '0; exc_req = 0; mask_we = 0; mask_wdata = '0;
   endtask

   initial begin
      reset = 1'b0;
      irq_in = '0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      expect_val(K_PC, 32'h0); expect_val(K_EPC, 32'h0); expect_val(K_IRQT, 0);
      expect_val(K_EXCT, 0); expect_val(K_ID, 0); expect_val(K_PEND, 0); expect_val(K_MASK, 0);
      drain();
      reset = 1'b1;

      // sequential run
      for (int i = 1; i <= 3; i++) begin
         expect_val(K_PC, 32'(4 * i)); expect_val(K_IRQT, 0); expect_val(K_EXCT, 0);
         step();
      end

      // branch taken backwards, not taken, and jump
      pc_sel = 3'd3; jr_target = 32'h100; expect_val(K_PC, 32'h100); step();
      pc_sel = 3'd1; branch_taken = 1; imm16 = 16'hFFFE; expect_val(K_PC, 32'hFC); step();
      pc_sel = 3'd3; jr_target = 32'h100; step();
      pc_sel = 3'd1; branch_taken = 0; expect_val(K_PC, 32'h104); step();
      pc_sel = 3'd3; jr_target = 32'h100; step();
      pc_sel = 3'd2; instr_index = 26'h40; expect_val(K_PC, 32'h100); step();

      // two IRQs together, lowest index first, second taken after kernel exit
      idle_inputs();
      pc_sel = 3'd3; jr_target = 32'h200; mask_we = 1; mask_wdata = 4'b0110;
      expect_val(K_PC, 32'h200); expect_val(K_MASK, 32'h6); step();
      mask_we = 0; irq_in = 4'b0110;
      expect_val(K_PC, 32'h200); expect_val(K_PEND, 32'h6); step();
      idle_inputs(); irq_in = 4'b0000;
      expect_val(K_PC, 32'h8000_0004); expect_val(K_EPC, 32'h200); expect_val(K_IRQT, 1);
      expect_val(K_ID, 1); expect_val(K_PEND, 32'h4); expect_val(K_KERN, 1); step();
      expect_val(K_PC, 32'h8000_0008); expect_val(K_IRQT, 0); expect_val(K_PEND, 32'h4); step();
      pc_sel = 3'd3; jr_target = 32'h200;
      expect_val(K_PC, 32'h200); expect_val(K_IRQT, 0); expect_val(K_KERN, 0); step();
      pc_sel = 3'd0;
      expect_val(K_PC, 32'h8000_0004); expect_val(K_IRQT, 1); expect_val(K_ID, 2);
      expect_val(K_EPC, 32'h200); expect_val(K_PEND, 32'h0); step();

      // jr kernel-bit masking
      pc_sel = 3'd3; jr_target = 32'h8000_0010; expect_val(K_PC, 32'h8000_0010); step();
      jr_target = 32'h40; expect_val(K_PC, 32'h40); step();
      jr_target = 32'h8000_0010; expect_val(K_PC, 32'h10); step();

      // exception beats a coincident eligible IRQ; illegal pc_sel is an exception
      jr_target = 32'h300; irq_in = 4'b0010;
      expect_val(K_PC, 32'h300); expect_val(K_PEND, 32'h2); step();
      pc_sel = 3'd0; irq_in = 4'b0000; exc_req = 1;
      expect_val(K_PC, 32'h8000_0008); expect_val(K_EPC, 32'h300); expect_val(K_EXCT, 1);
      expect_val(K_IRQT, 0); expect_val(K_PEND, 32'h2); step();
      exc_req = 0; pc_sel = 3'd3; jr_target = 32'h40;
      expect_val(K_PC, 32'h40); expect_val(K_EXCT, 0); step();
      pc_sel = 3'd5;
      expect_val(K_PC, 32'h8000_0008); expect_val(K_EPC, 32'h40); expect_val(K_EXCT, 1);
      expect_val(K_IRQT, 0); expect_val(K_PEND, 32'h2); step();
      pc_sel = 3'd0; mask_we = 1; mask_wdata = 4'b0001;
      expect_val(K_PC, 32'h8000_000C); expect_val(K_PC4, 32'h8000_0010);
      expect_val(K_MASK, 32'h1); step();
      mask_we = 0; pc_sel = 3'd3; jr_target = 32'h500; expect_val(K_PC, 32'h500); step();

      // stall: pc frozen, edge still latched, exc_req ignored
      pc_sel = 3'd0; stall = 1; irq_in = 4'b0001; exc_req = 1;
      expect_val(K_PC, 32'h500); expect_val(K_PEND, 32'h3); expect_val(K_EXCT, 0);
      expect_val(K_IRQT, 0); step();
      exc_req = 0;
      for (int i = 0; i < 2; i++) begin
         expect_val(K_PC, 32'h500); expect_val(K_IRQT, 0); expect_val(K_PEND, 32'h3); step();
      end
      stall = 0;
      expect_val(K_PC, 32'h8000_0004); expect_val(K_EPC, 32'h500); expect_val(K_IRQT, 1);
      expect_val(K_ID, 0); expect_val(K_PEND, 32'h2); step();

      // reset in the middle of a stall
      stall = 1; irq_in = 4'b0000;
      expect_val(K_PC, 32'h8000_0004); expect_val(K_IRQT, 0); step();
      irq_in = 4'b0001; expect_val(K_PEND, 32'h3); step();
      #2 reset = 1'b0;
      #1;
      expect_val(K_PC, 32'h0); expect_val(K_PEND, 32'h0); expect_val(K_EPC, 32'h0);
      expect_val(K_MASK, 32'h0); expect_val(K_IRQT, 0); expect_val(K_EXCT, 0);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pc_irq_unit.md
Name: pc_irq_unit

Overview:
- Parametrised next-PC and interrupt/exception sequencer for the MIPS core.
- Owns the PC register and computes the next PC: sequential, branch, jump, jr, IRQ vector or exception vector.
- Latches and masks multiple peripheral interrupt lines, arbitrates them by priority, and records EPC.
- Honours a pipeline stall input, so the same block serves the single-cycle core and future multicycle/pipelined cores.

Parameters:
- XLEN, 32, PC/data width (>=32; bit 31 is the kernel-mode bit).
- RESET_VEC, 32'h0000_0000, PC value after reset.
- IRQ_VEC, 32'h8000_0004, interrupt entry address.
- EXC_VEC, 32'h8000_0008, exception entry address.
- NUM_IRQ, 4, number of interrupt lines (1..16).
- IRQ_EDGE, 1, 1 = rising-edge-triggered sticky pending; 0 = level-sensitive.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low
- stall  in  1  1 = hold PC, take no events this cycle
- pc_sel  in  3  0 seq, 1 branch, 2 jump, 3 jr, 4..7 illegal
- branch_taken  in  1  branch condition from ALU (outZ[0])
- imm16  in  16  branch offset, in words
- instr_index  in  26  jump field
- jr_target  in  XLEN  rs value for jr
- exc_req  in  1  synchronous exception request for the current instruction
- irq_in  in  NUM_IRQ  peripheral interrupt lines, synchronous to clk
- mask_we  in  1  write strobe for the mask register
- mask_wdata  in  NUM_IRQ  new mask; 1 = enabled
- pc  out  XLEN  current PC
- pc_plus4  out  XLEN  pc+4, combinational
- epc  out  XLEN  saved return PC
- kernel  out  1  = pc[31]
- irq_taken  out  1  one-cycle pulse on interrupt entry
- irq_id  out  4  index of the line taken; valid with irq_taken
- exc_taken  out  1  one-cycle pulse on exception entry
- irq_pending  out  NUM_IRQ  pending register
- irq_mask  out  NUM_IRQ  mask register

Behaviour:
- Reset (async, reset=0): pc=RESET_VEC, epc=0, irq_pending=0, irq_mask=0, irq_taken=0, exc_taken=0, irq_id=0, edge-history register=0.
- pc_plus4 = pc+4, mod 2^XLEN; wrap-around is allowed.
- Normal next-PC candidates:
  - branch: pc_plus4 + sext(imm16)<<2 if branch_taken, else pc_plus4; bit 31 forced to pc[31].
  - jump: {pc[31], pc_plus4[30:28], instr_index, 2'b00}.
  - jr: jr_target, with bit 31 ANDed with pc[31]. User mode can never enter kernel; kernel jr to a target with bit31=0 is the return path.
- Pending logic:
  - IRQ_EDGE=1: pending[i] is set on irq_in[i] rising (0 in the previous cycle, 1 now). The edge history updates every cycle, including stall cycles.
  - IRQ_EDGE=0: pending mirrors irq_in.
- Eligibility: eligible = pending & mask. The selected line is the lowest index among eligible lines.
- Event priority per non-stalled cycle:
  1. Exception: (exc_req | pc_sel>=4). pc<=EXC_VEC, epc<=pc, exc_taken=1. Taken in kernel mode too.
  2. IRQ: |eligible & ~kernel. pc<=IRQ_VEC, epc<=pc (the current instruction is abandoned and re-executed on return), irq_taken=1, irq_id=selected index, pending[selected] cleared (edge mode).
  3. Otherwise, pc<=normal candidate.
- If an exception and an IRQ coincide, the exception wins and the IRQ stays pending.
- Event outputs: irq_taken, exc_taken and irq_id are registered pulses, high for exactly the cycle after entry, i.e. while pc holds the vector.
- Stall=1: pc, epc and pending-clear are held; no events are taken; exc_req is ignored; new edges still set pending; mask writes still apply.
- Mask write: irq_mask<=mask_wdata at the clock edge. The new mask takes effect for eligibility from the next cycle.
- A pending set and a clear on the same line in the same cycle: set wins.
- Kernel mode: IRQs are not taken; pending accumulates and is taken on the first non-stalled cycle after kernel is exited.
- Reset asserted mid-operation overrides everything at once; no event pulse is emitted.

Test Plan:
- Reset release, pc_sel=0 for 3 cycles -> pc = 0, 4, 8, 12; all flags 0.
- pc=0x100, pc_sel=1, branch_taken=1, imm16=16'hFFFE -> next pc=0xFC; with branch_taken=0 -> 0x104. pc_sel=2, instr_index=26'h40 -> pc=0x100.
- mask=4'b0110, irq_in[2] and irq_in[1] pulse together at pc=0x200 -> pc=0x80000004, epc=0x200, irq_id=1, pending=4'b0100. In kernel no second IRQ; jr to 0x200 -> pc=0x200, then next cycle irq_id=2.
- User-mode jr_target=0x8000_0010 -> pc=0x0000_0010. Kernel jr_target=0x8000_0010 -> pc=0x8000_0010.
- exc_req=1 and an eligible IRQ in the same cycle at pc=0x300 -> pc=0x80000008, epc=0x300, exc_taken=1, the IRQ stays pending. pc_sel=5 at 0x40 -> exception, epc=0x40.
- stall=1 for 3 cycles while irq_in[0] rises (mask=1) -> pc frozen, pending[0]=1, no irq_taken; the first unstalled cycle takes the IRQ. Reset asserted mid-stall -> pc=RESET_VEC, pending=0.
